dff_mem_bist: RTL and testbench

Built-in self-test initiator for the 64-word DFF memory tile. It drives the tile's packed control/address port and its write-data port, then reads back through the tile's registered read-data port. It runs a four-element march test (W, R/W̄, R̄/W, R) and reports pass/fail, an error count and the first failing access. It sits on the host side of the memory, in place of the bench or pad stimulus, and is the initiator for the memory's responder interface.

---
 rtl/dff_mem_bist.sv | 158 +++++++++++++++
 tb/tb_dff_mem_bist.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_mem_bist.sv
// March-test BIST initiator for the 64-word DFF memory tile.
// It runs the sequence W(P), R(P)/W(~P), descending R(~P)/W(P), then R(P), and reports pass/fail with first-failure details.
module dff_mem_bist #(
    parameter int          ADDR_W  = 6,
    parameter logic [7:0]  PATTERN = 8'h55
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [5:0] fail_addr,
    output logic [7:0] fail_exp,
    output logic [7:0] fail_act,
    output logic [7:0] mem_ctrl,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [3:0] {IDLE, M0, M1R, M1W, M2R, M2W, M3R, M3C, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [ADDR_W-1:0]  addr_inc;
    logic [ADDR_W-1:0]  addr_dec;
    logic               check_cycle;
    logic [7:0]         exp_data;
    logic               mismatch;
    logic               first_err;
    logic [7:0]         err_next;

    function automatic logic [7:0] access(input logic rd, input logic [ADDR_W-1:0] a);
        return {rd, 1'b1, 6'(a)};
    endfunction

    assign addr_inc = addr + 1'b1;
    assign addr_dec = addr - 1'b1;

    // Read data arrives in the cycle after the read command, so comparisons happen in the write/compare half of each pair.
    assign check_cycle = (state == M1W) || (state == M2W) || (state == M3C);
    assign exp_data    = (state == M2W) ? ~PATTERN : PATTERN;
    assign mismatch    = check_cycle && (mem_rdata != exp_data);
    assign first_err   = mismatch && (err_cnt == 8'd0);
    assign err_next    = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 8'd0;
            fail_addr <= 6'd0;
            fail_exp  <= 8'd0;
            fail_act  <= 8'd0;
            mem_ctrl  <= 8'h00;
            mem_wdata <= 8'h00;
        end else begin
            done    <= 1'b0;
            err_cnt <= err_next;
            if (first_err) begin
                fail_addr <= 6'(addr);
                fail_exp  <= exp_data;
                fail_act  <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    mem_ctrl <= 8'h00;
                    if (start) begin
                        err_cnt   <= 8'd0;
                        fail_addr <= 6'd0;
                        fail_exp  <= 8'd0;
                        fail_act  <= 8'd0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        addr      <= '0;
                        mem_ctrl  <= access(1'b0, '0);
                        mem_wdata <= PATTERN;
                        state     <= M0;
                    end
                end
                M0: begin
                    if (addr == LAST) begin
                        addr     <= '0;
                        mem_ctrl <= access(1'b1, '0);
                        state    <= M1R;
                    end else begin
                        addr      <= addr_inc;
                        mem_ctrl  <= access(1'b0, addr_inc);
                        mem_wdata <= PATTERN;
                    end
                end
                M1R: begin
                    mem_ctrl  <= access(1'b0, addr);
                    mem_wdata <= ~PATTERN;
                    state     <= M1W;
                end
                M1W: begin
                    if (addr == LAST) begin
                        addr     <= LAST;
                        mem_ctrl <= access(1'b1, LAST);
                        state    <= M2R;
                    end else begin
                        addr     <= addr_inc;
                        mem_ctrl <= access(1'b1, addr_inc);
                        state    <= M1R;
                    end
                end
                M2R: begin
                    mem_ctrl  <= access(1'b0, addr);
                    mem_wdata <= PATTERN;
                    state     <= M2W;
                end
                M2W: begin
                    if (addr == '0) begin
                        mem_ctrl <= access(1'b1, '0);
                        state    <= M3R;
                    end else begin
                        addr     <= addr_dec;
                        mem_ctrl <= access(1'b1, addr_dec);
                        state    <= M2R;
                    end
                end
                M3R: begin
                    mem_ctrl <= 8'h00;
                    state    <= M3C;
                end
                M3C: begin
                    if (addr == LAST) begin
                        mem_ctrl <= 8'h00;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_next == 8'd0);
                        state    <= DONE;
                    end else begin
                        addr     <= addr_inc;
                        mem_ctrl <= access(1'b1, addr_inc);
                        state    <= M3R;
                    end
                end
                DONE: begin
                    mem_ctrl <= 8'h00;
                    state    <= IDLE;
                end
                default: begin
                    mem_ctrl <= 8'h00;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_mem_bist.sv
// Directed bench for dff_mem_bist: a default 64x8 instance with a fault-injectable memory model,
// plus a small ADDR_W=3 / PATTERN=0 instance.
module tb_dff_mem_bist;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    int   fault_mode;

    int vec_count = 0;
    int miscompares = 0;

    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a, fexp_a, fact_a, ctrl_a, wd_a, rdata_a;
    logic [5:0] faddr_a;
    logic       busy_b, done_b, pass_b;
    logic [7:0] err_b, fexp_b, fact_b, ctrl_b, wd_b, rdata_b;
    logic [5:0] faddr_b;

    logic [7:0] mem_a [0:63];
    logic [7:0] mem_b [0:7];

    int ctrl_tr [0:200];
    int wd_tr   [0:200];

    wire       start_a = start && !sel;
    wire       start_b = start && sel;
    wire       busy_s  = sel ? busy_b : busy_a;
    wire       done_s  = sel ? done_b : done_a;
    wire [7:0] ctrl_s  = sel ? ctrl_b : ctrl_a;
    wire [7:0] wd_s    = sel ? wd_b : wd_a;

    always #5 clk = ~clk;

    dff_mem_bist dut (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_addr(faddr_a), .fail_exp(fexp_a), .fail_act(fact_a),
        .mem_ctrl(ctrl_a), .mem_wdata(wd_a), .mem_rdata(rdata_a)
    );

    dff_mem_bist #(.ADDR_W(3), .PATTERN(8'h00)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_addr(faddr_b), .fail_exp(fexp_b), .fail_act(fact_b),
        .mem_ctrl(ctrl_b), .mem_wdata(wd_b), .mem_rdata(rdata_b)
    );

    // Memory models: write commits at the edge ending a write cycle, read data registered one cycle after the command.
    always @(posedge clk) begin
        if (ctrl_a[6] && !ctrl_a[7])
            mem_a[ctrl_a[5:0]] <= (fault_mode == 1 && ctrl_a[5:0] == 6'h05) ? (wd_a & 8'hFE) : wd_a;
        if (ctrl_a[6] && ctrl_a[7])
            rdata_a <= (fault_mode == 2) ? 8'h00 : mem_a[ctrl_a[5:0]];
        if (ctrl_b[6] && !ctrl_b[7])
            mem_b[ctrl_b[2:0]] <= wd_b;
        if (ctrl_b[6] && ctrl_b[7])
            rdata_b <= mem_b[ctrl_b[2:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, " busy"},      32'(busy_a),  32'd0);
        checkOutput({tag, " done"},      32'(done_a),  32'd0);
        checkOutput({tag, " pass"},      32'(pass_a),  32'd0);
        checkOutput({tag, " err_cnt"},   32'(err_a),   32'd0);
        checkOutput({tag, " fail_addr"}, 32'(faddr_a), 32'd0);
        checkOutput({tag, " fail_exp"},  32'(fexp_a),  32'd0);
        checkOutput({tag, " fail_act"},  32'(fact_a),  32'd0);
        checkOutput({tag, " mem_ctrl"},  32'(ctrl_a),  32'h00);
        checkOutput({tag, " mem_wdata"}, 32'(wd_a),    32'h00);
    endtask

    // Pulses start, then follows the run cycle by cycle (cycle 1 = first cycle after the sampling edge).
    task automatic applyStimulus(input int glitch_at, input int reset_at,
                                 output int busy_cycles, output int done_at);
        busy_cycles = 0;
        done_at = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc <= 200) begin
                ctrl_tr[cyc] = int'(ctrl_s);
                wd_tr[cyc]   = int'(wd_s);
            end
            if (busy_s) busy_cycles++;
            if (done_s) begin
                done_at = cyc;
                break;
            end
            if (cyc == glitch_at) start = 1'b1;
            if (cyc == glitch_at + 1) start = 1'b0;
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkResetA("midrun reset");
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
    endtask

    int bc, dc;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel = 1'b0;
        fault_mode = 0;
        #3;
        checkResetA("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free run with mem_ctrl/mem_wdata trace
        applyStimulus(0, 0, bc, dc);
        checkOutput("ff busy cycles", 32'(bc), 32'd448);
        checkOutput("ff done cycle", 32'(dc), 32'd449);
        checkOutput("ff pass", 32'(pass_a), 32'd1);
        checkOutput("ff err_cnt", 32'(err_a), 32'd0);
        checkOutput("trace c1 ctrl", 32'(ctrl_tr[1]), 32'h40);
        checkOutput("trace c1 wdata", 32'(wd_tr[1]), 32'h55);
        checkOutput("trace c2 ctrl", 32'(ctrl_tr[2]), 32'h41);
        checkOutput("trace c2 wdata", 32'(wd_tr[2]), 32'h55);
        checkOutput("trace c3 ctrl", 32'(ctrl_tr[3]), 32'h42);
        checkOutput("trace c3 wdata", 32'(wd_tr[3]), 32'h55);
        checkOutput("m1 read ctrl", 32'(ctrl_tr[65]), 32'hC0);
        checkOutput("m1 write ctrl", 32'(ctrl_tr[66]), 32'h40);
        checkOutput("m1 write wdata", 32'(wd_tr[66]), 32'hAA);
        checkOutput("m2 first read", 32'(ctrl_tr[193]), 32'hFF);
        @(negedge clk);
        checkOutput("done one cycle", 32'(done_a), 32'd0);
        checkOutput("pass held", 32'(pass_a), 32'd1);
        checkOutput("idle ctrl", 32'(ctrl_a), 32'h00);

        // Bit 0 of address 5 stuck at 0
        fault_mode = 1;
        applyStimulus(0, 0, bc, dc);
        checkOutput("stuck done cycle", 32'(dc), 32'd449);
        checkOutput("stuck err_cnt", 32'(err_a), 32'd2);
        checkOutput("stuck fail_addr", 32'(faddr_a), 32'h05);
        checkOutput("stuck fail_exp", 32'(fexp_a), 32'h55);
        checkOutput("stuck fail_act", 32'(fact_a), 32'h54);
        checkOutput("stuck pass", 32'(pass_a), 32'd0);

        // Read data always zero
        fault_mode = 2;
        applyStimulus(0, 0, bc, dc);
        checkOutput("zero err_cnt", 32'(err_a), 32'd192);
        checkOutput("zero fail_addr", 32'(faddr_a), 32'h00);
        checkOutput("zero fail_exp", 32'(fexp_a), 32'h55);
        checkOutput("zero fail_act", 32'(fact_a), 32'h00);
        checkOutput("zero pass", 32'(pass_a), 32'd0);

        // start re-asserted during M1 is ignored
        fault_mode = 0;
        applyStimulus(100, 0, bc, dc);
        checkOutput("glitch busy cycles", 32'(bc), 32'd448);
        checkOutput("glitch done cycle", 32'(dc), 32'd449);
        checkOutput("glitch pass", 32'(pass_a), 32'd1);
        @(negedge clk);
        checkOutput("glitch no relaunch", 32'(busy_a), 32'd0);

        // Reset in the middle of M2, then a clean rerun
        applyStimulus(0, 250, bc, dc);
        checkOutput("post reset idle busy", 32'(busy_a), 32'd0);
        applyStimulus(0, 0, bc, dc);
        checkOutput("rerun busy cycles", 32'(bc), 32'd448);
        checkOutput("rerun pass", 32'(pass_a), 32'd1);
        checkOutput("rerun err_cnt", 32'(err_a), 32'd0);

        // Small instance: ADDR_W=3, PATTERN=0
        sel = 1'b1;
        applyStimulus(0, 0, bc, dc);
        checkOutput("small busy cycles", 32'(bc), 32'd56);
        checkOutput("small done cycle", 32'(dc), 32'd57);
        checkOutput("small pass", 32'(pass_b), 32'd1);
        checkOutput("small err_cnt", 32'(err_b), 32'd0);
        checkOutput("small c1 ctrl", 32'(ctrl_tr[1]), 32'h40);
        checkOutput("small c1 wdata", 32'(wd_tr[1]), 32'h00);
        checkOutput("small m1 read", 32'(ctrl_tr[9]), 32'hC0);
        checkOutput("small m1 write", 32'(ctrl_tr[10]), 32'h40);
        checkOutput("small m1 wdata", 32'(wd_tr[10]), 32'hFF);
        checkOutput("small m2 read", 32'(ctrl_tr[25]), 32'hC7);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
